// File: rtl/memory_bus_arbiter_if.sv
// ============================================================================
// Module   : memory_bus_arbiter_if
// Brief    : One requester port of memory_bus_arbiter (request, command, reply).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface memory_bus_arbiter_if;
    logic        req;
    logic [15:0] address;
    logic [15:0] data_in;
    logic [1:0]  write_mask;
    logic        write_enable;
    logic        ready;
    logic [15:0] data_out;

    modport master (
        output req, address, data_in, write_mask, write_enable,
        input  ready, data_out
    );

    modport slave (
        input  req, address, data_in, write_mask, write_enable,
        output ready, data_out
    );
endinterface

`default_nettype wire

// File: rtl/memory_bus_arbiter.sv
// ============================================================================
// Module   : memory_bus_arbiter
// Brief    : Two-master arbiter in front of memory_bus; latches the winning
//            command, drives the bus for WAIT_CYCLES+1 cycles, pulses ready.
//            Macro ARB_ROUND_ROBIN_EN selects alternating tie-break (else fixed).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module memory_bus_arbiter #(
    parameter int WAIT_CYCLES = 1
) (
    input  wire logic              clk,
    input  wire logic              reset,
    memory_bus_arbiter_if.slave    port_0,
    memory_bus_arbiter_if.slave    port_1,
    output logic [15:0]            bus_address,
    output logic [15:0]            bus_data_in,
    output logic [1:0]             bus_write_mask,
    output logic                   bus_enable,
    output logic                   bus_write_enable,
    input  wire logic [15:0]       bus_data_out,
    output logic [1:0]             grant,
    output logic                   busy
);

    localparam logic [3:0] c_WAIT     = 4'(WAIT_CYCLES);
    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_ACCESS   = 2'd1;
    localparam logic [1:0] S_COMPLETE = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [3:0]  r_count;
    logic [15:0] r_address;
    logic [15:0] r_data_in;
    logic [1:0]  r_write_mask;
    logic        r_write_enable;
    logic [1:0]  r_grant;
    logic        r_last_grant;     // 1 = port 1 owned the last transaction
    logic        r_ready_0;
    logic        r_ready_1;
    logic [15:0] r_data_out_0;
    logic [15:0] r_data_out_1;
    logic        w_any_req;
    logic        w_tie_pick_1;
    logic        w_pick_1;

`ifdef ARB_ROUND_ROBIN_EN
    assign w_tie_pick_1 = ~r_last_grant;
`else
    // History is still tracked here, but fixed priority never lets it win a tie.
    assign w_tie_pick_1 = r_last_grant & 1'b0;
`endif

    assign w_any_req = port_0.req | port_1.req;
    assign w_pick_1  = port_1.req & (~port_0.req | w_tie_pick_1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:     if (w_any_req) w_next_state = S_ACCESS;
            S_ACCESS:   if (r_count == 4'd0) w_next_state = S_COMPLETE;
            S_COMPLETE: w_next_state = S_IDLE;
            default:    w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        bus_address      = 16'h0000;
        bus_data_in      = 16'h0000;
        bus_write_mask   = 2'b00;
        bus_enable       = 1'b0;
        bus_write_enable = 1'b0;
        if (r_state == S_ACCESS) begin
            bus_address      = r_address;
            bus_data_in      = r_data_in;
            bus_write_mask   = r_write_mask;
            bus_enable       = 1'b1;
            bus_write_enable = r_write_enable;
        end
    end

    assign busy            = (r_state == S_ACCESS) || (r_state == S_COMPLETE);
    assign grant           = r_grant;
    assign port_0.ready    = r_ready_0;
    assign port_1.ready    = r_ready_1;
    assign port_0.data_out = r_data_out_0;
    assign port_1.data_out = r_data_out_1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count        <= 4'd0;
            r_address      <= 16'h0000;
            r_data_in      <= 16'h0000;
            r_write_mask   <= 2'b00;
            r_write_enable <= 1'b0;
            r_grant        <= 2'b00;
            r_last_grant   <= 1'b1;
            r_ready_0      <= 1'b0;
            r_ready_1      <= 1'b0;
            r_data_out_0   <= 16'h0000;
            r_data_out_1   <= 16'h0000;
        end else begin
            r_ready_0 <= 1'b0;
            r_ready_1 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_count <= c_WAIT;
                        if (w_pick_1) begin
                            r_grant        <= 2'b10;
                            r_address      <= port_1.address;
                            r_data_in      <= port_1.data_in;
                            r_write_mask   <= port_1.write_mask;
                            r_write_enable <= port_1.write_enable;
                        end else begin
                            r_grant        <= 2'b01;
                            r_address      <= port_0.address;
                            r_data_in      <= port_0.data_in;
                            r_write_mask   <= port_0.write_mask;
                            r_write_enable <= port_0.write_enable;
                        end
                    end
                end
                S_ACCESS: begin
                    if (r_count != 4'd0) begin
                        r_count <= r_count - 4'd1;
                    end else begin
                        r_ready_0 <= r_grant[0];
                        r_ready_1 <= r_grant[1];
                        if (!r_write_enable && r_grant[0]) r_data_out_0 <= bus_data_out;
                        if (!r_write_enable && r_grant[1]) r_data_out_1 <= bus_data_out;
                    end
                end
                S_COMPLETE: begin
                    r_last_grant <= r_grant[1];
                    r_grant      <= 2'b00;
                end
                default: r_grant <= 2'b00;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_memory_bus_arbiter.sv
// ============================================================================
// Module   : tb_memory_bus_arbiter
// Brief    : Directed self-checking bench for memory_bus_arbiter (WAIT_CYCLES=1).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_memory_bus_arbiter;

    logic        clk;
    logic        reset;
    logic [15:0] bus_address;
    logic [15:0] bus_data_in;
    logic [1:0]  bus_write_mask;
    logic        bus_enable;
    logic        bus_write_enable;
    logic [15:0] bus_data_out;
    logic [1:0]  grant;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    memory_bus_arbiter_if p0 ();
    memory_bus_arbiter_if p1 ();

    memory_bus_arbiter #(.WAIT_CYCLES(1)) dut (
        .clk              (clk),
        .reset            (reset),
        .port_0           (p0.slave),
        .port_1           (p1.slave),
        .bus_address      (bus_address),
        .bus_data_in      (bus_data_in),
        .bus_write_mask   (bus_write_mask),
        .bus_enable       (bus_enable),
        .bus_write_enable (bus_write_enable),
        .bus_data_out     (bus_data_out),
        .grant            (grant),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] exp_grant [4];

    initial begin
`ifdef ARB_ROUND_ROBIN_EN
        exp_grant[0] = 2'b01; exp_grant[1] = 2'b10; exp_grant[2] = 2'b01; exp_grant[3] = 2'b10;
`else
        exp_grant[0] = 2'b01; exp_grant[1] = 2'b01; exp_grant[2] = 2'b01; exp_grant[3] = 2'b01;
`endif
        reset = 1'b0;
        bus_data_out = 16'h0000;
        p0.req = 1'b1; p0.address = 16'h4010; p0.data_in = 16'h0000;
        p0.write_mask = 2'b11; p0.write_enable = 1'b0;
        p1.req = 1'b0; p1.address = 16'h0000; p1.data_in = 16'h0000;
        p1.write_mask = 2'b00; p1.write_enable = 1'b0;

        // Reset held with a pending request
        tick(); tick();
        check_value("rst_grant", 32'(grant), 32'h0);
        check_value("rst_busy", 32'(busy), 32'h0);
        check_value("rst_bus_en", 32'(bus_enable), 32'h0);
        check_value("rst_bus_addr", 32'(bus_address), 32'h0);
        check_value("rst_ready0", 32'(p0.ready), 32'h0);
        check_value("rst_dout0", 32'(p0.data_out), 32'h0);
        check_value("rst_dout1", 32'(p1.data_out), 32'h0);
        reset = 1'b1;

        // Port 0 read of 0x4010
        tick();
        check_value("rd_grant", 32'(grant), 32'h1);
        check_value("rd_busy", 32'(busy), 32'h1);
        check_value("rd_bus_en1", 32'(bus_enable), 32'h1);
        check_value("rd_bus_we1", 32'(bus_write_enable), 32'h0);
        check_value("rd_bus_addr", 32'(bus_address), 32'h4010);
        bus_data_out = 16'h1234;
        tick();
        check_value("rd_bus_en2", 32'(bus_enable), 32'h1);
        check_value("rd_ready_early", 32'(p0.ready), 32'h0);
        tick();
        check_value("rd_ready0", 32'(p0.ready), 32'h1);
        check_value("rd_dout0", 32'(p0.data_out), 32'h1234);
        check_value("rd_cpl_bus_en", 32'(bus_enable), 32'h0);
        check_value("rd_cpl_busy", 32'(busy), 32'h1);
        p0.req = 1'b0;
        tick();
        check_value("rd_idle_ready0", 32'(p0.ready), 32'h0);
        check_value("rd_idle_grant", 32'(grant), 32'h0);
        check_value("rd_idle_busy", 32'(busy), 32'h0);
        check_value("rd_hold_dout0", 32'(p0.data_out), 32'h1234);

        // Port 1 write; request dropped and address changed mid-access
        p1.req = 1'b1; p1.address = 16'h0020; p1.data_in = 16'hBEEF;
        p1.write_mask = 2'b00; p1.write_enable = 1'b1;
        bus_data_out = 16'hDEAD;
        tick();
        check_value("wr_grant", 32'(grant), 32'h2);
        check_value("wr_bus_we1", 32'(bus_write_enable), 32'h1);
        check_value("wr_bus_din", 32'(bus_data_in), 32'hBEEF);
        check_value("wr_bus_mask", 32'(bus_write_mask), 32'h0);
        p1.req = 1'b0; p1.address = 16'h8000;
        tick();
        check_value("wr_bus_addr_held", 32'(bus_address), 32'h0020);
        check_value("wr_bus_we2", 32'(bus_write_enable), 32'h1);
        tick();
        check_value("wr_ready1", 32'(p1.ready), 32'h1);
        check_value("wr_ready0_quiet", 32'(p0.ready), 32'h0);
        check_value("wr_dout1_unchanged", 32'(p1.data_out), 32'h0);
        check_value("wr_cpl_bus_we", 32'(bus_write_enable), 32'h0);
        tick();
        check_value("wr_ready1_once", 32'(p1.ready), 32'h0);
        tick();
        check_value("wr_no_reservice", 32'(busy), 32'h0);

        // Both ports requesting for four transactions
        p0.req = 1'b1; p0.address = 16'h1000; p0.write_enable = 1'b0;
        p1.req = 1'b1; p1.address = 16'h2000; p1.write_enable = 1'b0;
        bus_data_out = 16'h5A5A;
        for (int t = 0; t < 4; t++) begin
            tick();
            check_value($sformatf("tie_grant%0d", t), 32'(grant), 32'(exp_grant[t]));
            check_value($sformatf("tie_addr%0d", t), 32'(bus_address),
                        (exp_grant[t] == 2'b01) ? 32'h1000 : 32'h2000);
            tick();
            tick();
            check_value($sformatf("tie_ready0_%0d", t), 32'(p0.ready), 32'(exp_grant[t][0]));
            check_value($sformatf("tie_ready1_%0d", t), 32'(p1.ready), 32'(exp_grant[t][1]));
            if (t == 3) begin
                p0.req = 1'b0;
                p1.req = 1'b0;
            end
            tick();
        end
        check_value("tie_idle_busy", 32'(busy), 32'h0);

        // Reset pulsed during the second access cycle of a port 0 write
        p0.req = 1'b1; p0.address = 16'h3000; p0.data_in = 16'h0F0F; p0.write_enable = 1'b1;
        tick();
        check_value("ar_bus_we1", 32'(bus_write_enable), 32'h1);
        tick();
        check_value("ar_bus_en2", 32'(bus_enable), 32'h1);
        #2 reset = 1'b0;
        #1;
        check_value("ar_bus_en_drop", 32'(bus_enable), 32'h0);
        check_value("ar_bus_we_drop", 32'(bus_write_enable), 32'h0);
        check_value("ar_busy_drop", 32'(busy), 32'h0);
        check_value("ar_dout0_cleared", 32'(p0.data_out), 32'h0);
        tick();
        check_value("ar_no_ready0", 32'(p0.ready), 32'h0);
        reset = 1'b1;
        tick();
        check_value("ar_regrant", 32'(grant), 32'h1);
        check_value("ar_readdr", 32'(bus_address), 32'h3000);
        check_value("ar_rewe", 32'(bus_write_enable), 32'h1);
        tick();
        tick();
        check_value("ar_ready0", 32'(p0.ready), 32'h1);
        check_value("ar_dout0_write", 32'(p0.data_out), 32'h0);
        p0.req = 1'b0;
        tick();
        check_value("ar_final_idle", 32'(busy), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
